// File: rtl/ram_port_ctl.sv
// Data RAM port initiator: decode-stage address, write-back-stage store data/enable,
// load return aligned to write-back with store-to-load forwarding (enabled by RAM_PORT_FWD_EN).
module ram_port_ctl (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        DC_VALID,
    input  logic [1:0]  DC_OP,
    input  logic [7:0]  DC_ADDR,
    input  logic        FLUSH,
    input  logic [15:0] WB_DATA,
    input  logic [15:0] RAM_OUT,
    output logic [7:0]  RAM_ADDR,
    output logic [15:0] RAM_IN,
    output logic        RAM_WEN,
    output logic [15:0] LOAD_DATA,
    output logic        LOAD_VALID,
    output logic        HAZARD,
    output logic [15:0] FWD_CNT
);

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    // Only plain RAM words take part in forwarding; IO addresses 64/65 never do.
    function automatic logic fwd_addr_ok(input logic [7:0] addr);
        return addr < 8'd64;
    endfunction

    function automatic logic ram_read_ok(input logic [7:0] addr);
        return (addr < 8'd64) || (addr == 8'd65);
    endfunction

    logic        s1_valid_r;
    logic [1:0]  s1_op_r;
    logic [7:0]  s1_addr_r;
    logic        s1_fwd_r;
`ifdef RAM_PORT_FWD_EN
    logic [15:0] s1_data_r;
`endif
    logic        s2_store_r;
    logic [7:0]  s2_addr_r;
    logic [15:0] s2_data_r;
    logic        load_valid_r;
    logic        hazard_r;
    logic [15:0] fwd_cnt_r;

    logic        dc_enter_s;
    logic        s1_live_s;
    logic        fwd_a_s;
    logic        fwd_b_s;
    logic [15:0] s2_data_nxt_s;

    assign dc_enter_s = DC_VALID && ((DC_OP == OP_LOAD) || (DC_OP == OP_STORE));
    assign s1_live_s  = s1_valid_r && !FLUSH;
    assign fwd_a_s    = DC_VALID && (DC_OP == OP_LOAD) && s2_store_r &&
                        (DC_ADDR == s2_addr_r) && fwd_addr_ok(DC_ADDR);
    assign fwd_b_s    = s1_live_s && (s1_op_r == OP_LOAD) && s2_store_r &&
                        (s1_addr_r == s2_addr_r) && fwd_addr_ok(s1_addr_r);

    // Write-back data select: the younger in-flight store (b) beats an older forward (a).
    always_comb begin
        s2_data_nxt_s = 16'h0000;
`ifdef RAM_PORT_FWD_EN
        if (fwd_b_s) begin
            s2_data_nxt_s = WB_DATA;
        end else if (s1_fwd_r) begin
            s2_data_nxt_s = s1_data_r;
        end else if (ram_read_ok(s1_addr_r)) begin
            s2_data_nxt_s = RAM_OUT;
        end else begin
            s2_data_nxt_s = 16'h0000;
        end
`else
        if (ram_read_ok(s1_addr_r)) begin
            s2_data_nxt_s = RAM_OUT;
        end else begin
            s2_data_nxt_s = 16'h0000;
        end
`endif
    end

    // Two-entry pipeline (S1, S2) plus saturating forwarded-load counter.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            s1_valid_r   <= 1'b0;
            s1_op_r      <= 2'b00;
            s1_addr_r    <= 8'h00;
            s1_fwd_r     <= 1'b0;
`ifdef RAM_PORT_FWD_EN
            s1_data_r    <= 16'h0000;
`endif
            s2_store_r   <= 1'b0;
            s2_addr_r    <= 8'h00;
            s2_data_r    <= 16'h0000;
            load_valid_r <= 1'b0;
            hazard_r     <= 1'b0;
            fwd_cnt_r    <= 16'h0000;
        end else begin
            s1_valid_r   <= dc_enter_s;
            s1_op_r      <= DC_OP;
            s1_addr_r    <= DC_ADDR;
            s1_fwd_r     <= fwd_a_s;
`ifdef RAM_PORT_FWD_EN
            s1_data_r    <= fwd_a_s ? WB_DATA : 16'h0000;
`endif
            s2_store_r   <= s1_live_s && (s1_op_r == OP_STORE);
            s2_addr_r    <= s1_addr_r;
            s2_data_r    <= s2_data_nxt_s;
            load_valid_r <= s1_live_s && (s1_op_r == OP_LOAD);
            hazard_r     <= s1_live_s && (s1_op_r == OP_LOAD) && (fwd_b_s || s1_fwd_r);
            if (hazard_r && (fwd_cnt_r != 16'hFFFF)) begin
                fwd_cnt_r <= fwd_cnt_r + 16'd1;
            end
        end
    end

    assign RAM_ADDR   = DC_VALID ? DC_ADDR : 8'h00;
    assign RAM_IN     = WB_DATA;
    assign RAM_WEN    = RESET_N && s2_store_r && (s2_addr_r <= 8'd64);
    assign LOAD_DATA  = s2_data_r;
    assign LOAD_VALID = load_valid_r;
    assign HAZARD     = hazard_r;
    assign FWD_CNT    = fwd_cnt_r;

endmodule

// File: doc/ram_port_ctl.md
# ram_port_ctl

Pipeline-side initiator for the decode-read / write-back-write data RAM port. It drives the RAM's address, write data and write enable so that a store's address leaves in the decode stage and its data and enable leave two cycles later in write-back. It returns load data aligned to write-back. It resolves read-after-write hazards against stores still in flight by forwarding. It sits between the CPU decode/execute/write-back stages and the 64-word data RAM with its IO64 output and IO65 input.

## Interface
- No parameters. Word width is 16 bits and address width is 8 bits, both fixed.
- CLK  in  1  sole clock; all state changes on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- DC_VALID  in  1  decode-stage operation valid.
- DC_OP  in  2  operation code: 00 none, 01 load, 10 store, 11 none.
- DC_ADDR  in  8  memory address of the decode-stage operation.
- FLUSH  in  1  kills the operation currently in stage 1 (branch taken).
- WB_DATA  in  16  store data, presented by the pipeline in the store's write-back cycle.
- RAM_OUT  in  16  registered RAM read data; valid in the cycle after the address is presented.
- RAM_ADDR  out  8  combinational: DC_ADDR when DC_VALID is high, else 8'h00.
- RAM_IN  out  16  combinational: equal to WB_DATA.
- RAM_WEN  out  1  combinational: stage-2 store valid and stage-2 address ≤ 64.
- LOAD_DATA  out  16  load result, valid while LOAD_VALID is high.
- LOAD_VALID  out  1  high during the write-back cycle of a surviving load.
- HAZARD  out  1  high with LOAD_VALID when a forwarding condition applied to that load.
- FWD_CNT  out  16  saturating count of forwarded loads.

## Operation
- Stages: DC (cycle t), S1 (t+1), S2/write-back (t+2).
- Each stage entry holds: valid, op, addr, data, fwd flag.
- Advance every cycle. There are no stalls.
- A DC entry enters S1 only if DC_VALID is high and DC_OP is 01 or 10.
- FLUSH clears the S1 valid bit before that entry advances. A flushed store never raises RAM_WEN. A flushed load never raises LOAD_VALID.
- Load data path:
  - S2 data ← RAM_OUT at the end of S1, for addresses < 64 or = 65.
  - Addresses 64 and 66–255 load 16'h0000.
- Forward condition (a): DC load and S2 store with equal addresses (address < 64). At the end of t, latch WB_DATA into the S1 data field and set fwd.
- Forward condition (b): S1 load and S2 store with equal addresses (address < 64). At the end of t+1, capture WB_DATA into the S2 data field instead of RAM_OUT and set fwd.
- Priority: (b) overrides the RAM_OUT capture and any earlier (a) value, because it is the younger store.
- Address 65 (IO input) and address 64 (IO output) are never forwarded.
- LOAD_DATA = S2 data; LOAD_VALID = S2 valid load; HAZARD = S2 fwd & LOAD_VALID.
- FWD_CNT increments by 1 for each cycle in which HAZARD is high, and saturates at 16'hFFFF.

## Timing
- Reset (RESET_N low at a clock edge):
  - clears all stage valid and fwd bits, and zeroes all data fields and FWD_CNT;
  - on the following cycle LOAD_VALID = 0, HAZARD = 0, LOAD_DATA = 0, RAM_WEN = 0, FWD_CNT = 0;
  - during reset RAM_WEN is forced to 0 combinationally.
- Store issued at t: address on RAM_ADDR in t; RAM_WEN = 1 and RAM_IN = WB_DATA in t+2; the RAM commits at the end of t+2.
- Load issued at t: LOAD_VALID = 1 in t+2. Latency is 2 cycles and throughput is 1 per cycle.
- Back-to-back store and load to the same address at gaps of 1 and 2 cycles must both return the store data.
- A gap of 3 or more cycles reads the RAM directly.
- A store to an address ≥ 65 never raises RAM_WEN.
- Reset in mid-stream discards every in-flight operation; no late RAM_WEN follows.

## Configuration
- RAM_PORT_FWD_EN defined: forwarding as specified above.
- RAM_PORT_FWD_EN undefined:
  - LOAD_DATA always comes from RAM_OUT (or 0 for addresses 64 and 66–255), so it may be stale;
  - HAZARD still flags conditions (a) and (b);
  - FWD_CNT counts flagged loads.

## Test plan
- Reset with RAM_OUT = 16'hFFFF and DC_VALID = 1 -> the cycle after the reset edge shows LOAD_VALID = 0, RAM_WEN = 0, FWD_CNT = 0, LOAD_DATA = 0.
- Store to address 5 at t with WB_DATA = 16'h1234 at t+2; load from address 5 at t+3 -> RAM_WEN is high only in t+2; LOAD_DATA = 16'h1234 at t+5; HAZARD = 0.
- Store to address 7 (data 16'hBEEF) at t; loads from address 7 at t+1 and t+2 -> both return 16'hBEEF, with HAZARD = 1 each time; FWD_CNT = 2.
- Store to address 9 at t with FLUSH at t+1 -> RAM_WEN stays 0 in t+2; a subsequent load from address 9 returns the old RAM value.
- Store to address 64 (16'h00AA), then load from address 64, then load from address 65 with RAM_OUT = 16'h5555 -> RAM_WEN = 1 for the store; the loads return 16'h0000 and 16'h5555; no HAZARD.
- FWD_CNT preset near 16'hFFFF via repeated forwarding -> holds at 16'hFFFF. With RAM_PORT_FWD_EN undefined, the same scenario as the store-to-address-7 test returns stale RAM data, with HAZARD = 1.
